por_reset_sequencer: RTL and testbench



---
 rtl/por_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_por_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/por_reset_sequencer.sv
// POR synchroniser, glitch filter and staged release of NUM_CH active-low domain resets.
// Software can request a full re-sequence once release has begun.
module por_reset_sequencer #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_CYC  = 16,
   parameter int unsigned STAGE_DLY   = 32,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              por_n_i,
   input  logic              sw_rst_req_i,
   output logic [NUM_CH-1:0] rst_n_o,
   output logic              seq_done_o,
   output logic [1:0]        state_o
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] L_FILT   = CNT_W'(FILTER_CYC);
   localparam logic [CNT_W-1:0] L_STG_M1 = CNT_W'(STAGE_DLY - 1);
   localparam logic [IDX_W-1:0] L_LAST   = IDX_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      StHold    = 2'd0,
      StFilter  = 2'd1,
      StRelease = 2'd2,
      StDone    = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_por_s;

   state_t            r_state, w_state;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic [NUM_CH-1:0] r_rst_n, w_rst_n;
   logic              r_done, w_done;

   assign w_por_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_rst_n = r_rst_n;
      w_done  = r_done;
      if (!w_por_s) begin
         w_state = StHold;
         w_cnt   = '0;
         w_idx   = '0;
         w_rst_n = '0;
         w_done  = 1'b0;
      end else if (sw_rst_req_i && (r_state == StRelease || r_state == StDone)) begin
         // Re-entering FILTER guarantees a full filter window of assertion.
         w_state = StFilter;
         w_cnt   = CNT_W'(1);
         w_idx   = '0;
         w_rst_n = '0;
         w_done  = 1'b0;
      end else begin
         unique case (r_state)
            StHold: begin
               w_rst_n = '0;
               w_done  = 1'b0;
               w_state = StFilter;
               w_cnt   = CNT_W'(1);
            end
            StFilter: begin
               if (r_cnt == L_FILT) begin
                  w_state = StRelease;
                  w_cnt   = '0;
                  w_idx   = '0;
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            StRelease: begin
               if (r_cnt == L_STG_M1) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (r_idx == IDX_W'(k)) w_rst_n[k] = 1'b1;
                  end
                  w_cnt = '0;
                  if (r_idx == L_LAST) begin
                     w_state = StDone;
                     w_done  = 1'b1;
                  end else begin
                     w_idx = r_idx + IDX_W'(1);
                  end
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            StDone: begin
               w_rst_n = '1;
               w_done  = 1'b1;
            end
            default: w_state = StHold;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_state <= StHold;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rst_n <= '0;
         r_done  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], por_n_i};
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_rst_n <= w_rst_n;
         r_done  <= w_done;
      end
   end

   assign rst_n_o    = r_rst_n;
   assign seq_done_o = r_done;
   assign state_o    = r_state;

`ifndef SYNTHESIS
   a_cnt_w_fits: assert property (@(posedge clk)
      (64'(FILTER_CYC) < (64'd1 << CNT_W)) && (64'(STAGE_DLY) < (64'd1 << CNT_W)));
   a_filt_no_wrap: assert property (@(posedge clk) disable iff (rst)
      (r_state == StFilter) |-> (r_cnt <= L_FILT));
   a_rel_no_wrap: assert property (@(posedge clk) disable iff (rst)
      (r_state == StRelease) |-> (r_cnt <= L_STG_M1));
   a_idx_range: assert property (@(posedge clk) disable iff (rst) r_idx <= L_LAST);
   a_thermo: assert property (@(posedge clk) disable iff (rst)
      (r_rst_n & (r_rst_n + NUM_CH'(1))) == '0);
`endif

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench: release timing table plus glitch, abort, software and small-parameter cases.
module tb_por_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst, por_n, sw;
   logic [3:0] rst_n;
   logic       done;
   logic [1:0] st;
   logic       rst2, por2, sw2;
   logic [0:0] rst_n2;
   logic       done2;
   logic [1:0] st2;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   por_reset_sequencer #(
      .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYC(16), .STAGE_DLY(32), .CNT_W(8)
   ) u_dut (
      .clk(clk), .rst(rst), .por_n_i(por_n), .sw_rst_req_i(sw),
      .rst_n_o(rst_n), .seq_done_o(done), .state_o(st)
   );

   por_reset_sequencer #(
      .NUM_CH(1), .SYNC_STAGES(2), .FILTER_CYC(1), .STAGE_DLY(1), .CNT_W(8)
   ) u_dut_min (
      .clk(clk), .rst(rst2), .por_n_i(por2), .sw_rst_req_i(sw2),
      .rst_n_o(rst_n2), .seq_done_o(done2), .state_o(st2)
   );

   typedef struct {
      int         off;
      logic [3:0] rst_n;
      logic       done;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Call at a negedge; returns the cycle at which the state was first seen.
   task automatic wait_st(input int sel, input logic [1:0] s, input int budget,
                          input string nm, output int at);
      int n = 0;
      while (((sel == 0) ? st : st2) != s && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (((sel == 0) ? st : st2) != s) begin
         errors++;
         $display("FAIL %s: state stuck at %0d, expected %0d within %0d cycles",
                  nm, (sel == 0) ? st : st2, s, budget);
      end
      at = cyc;
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic apply_table(input string pfx, input int e);
      for (int i = 0; i < 12; i++) begin
         goto(e + tbl[i].off);
         chk($sformatf("%s_tbl%0d_rst_n", pfx, i), rst_n, tbl[i].rst_n);
         chk($sformatf("%s_tbl%0d_done", pfx, i), done, tbl[i].done);
         chk($sformatf("%s_tbl%0d_state", pfx, i), st, tbl[i].st);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e, e2, p, x, r;
      tbl[0]  = '{0,   4'b0000, 1'b0, 2'd1};
      tbl[1]  = '{15,  4'b0000, 1'b0, 2'd1};
      tbl[2]  = '{16,  4'b0000, 1'b0, 2'd2};
      tbl[3]  = '{47,  4'b0000, 1'b0, 2'd2};
      tbl[4]  = '{48,  4'b0001, 1'b0, 2'd2};
      tbl[5]  = '{79,  4'b0001, 1'b0, 2'd2};
      tbl[6]  = '{80,  4'b0011, 1'b0, 2'd2};
      tbl[7]  = '{111, 4'b0011, 1'b0, 2'd2};
      tbl[8]  = '{112, 4'b0111, 1'b0, 2'd2};
      tbl[9]  = '{143, 4'b0111, 1'b0, 2'd2};
      tbl[10] = '{144, 4'b1111, 1'b1, 2'd3};
      tbl[11] = '{150, 4'b1111, 1'b1, 2'd3};

      rst = 1'b1; por_n = 1'b1; sw = 1'b0;
      rst2 = 1'b1; por2 = 1'b1; sw2 = 1'b0;

      // 1: reset, then nominal sequence
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_rst_rst_n", rst_n, 4'b0000);
         chk("t1_rst_state", st, 2'd0);
         chk("t1_rst_done", done, 1'b0);
      end
      rst = 1'b0;
      r = cyc;
      wait_st(0, 2'd1, 20, "t1_enter_filter", e);
      chk("t1_E_latency", e - r, 3);
      apply_table("t1", e);

      // 2: POR drop from DONE, then a one-cycle glitch during FILTER
      por_n = 1'b0;
      wait_st(0, 2'd0, 10, "t2_hold", x);
      chk("t2_hold_rst_n", rst_n, 4'b0000);
      chk("t2_hold_done", done, 1'b0);
      por_n = 1'b1;
      wait_st(0, 2'd1, 10, "t2_filter", e);
      goto(e + 9);
      por_n = 1'b0;
      @(negedge clk);
      por_n = 1'b1;
      @(negedge clk);
      chk("t2_glitch_pending", st, 2'd1);
      @(negedge clk);
      chk("t2_glitch_hold", st, 2'd0);
      wait_st(0, 2'd1, 10, "t2_refilter", e2);
      chk("t2_new_E", e2 - e, 13);
      goto(e2 + 15);
      chk("t2_restart_state", st, 2'd1);
      goto(e2 + 47);
      chk("t2_pre_release", rst_n, 4'b0000);
      goto(e2 + 48);
      chk("t2_first_release", rst_n, 4'b0001);

      // 3: POR falls while two channels released
      goto(e2 + 85);
      chk("t3_mid_rst_n", rst_n, 4'b0011);
      por_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_sync_delay_rst_n", rst_n, 4'b0011);
      chk("t3_sync_delay_state", st, 2'd2);
      @(negedge clk);
      chk("t3_abort_rst_n", rst_n, 4'b0000);
      chk("t3_abort_state", st, 2'd0);
      chk("t3_abort_done", done, 1'b0);
      por_n = 1'b1;
      wait_st(0, 2'd1, 10, "t3_recover", e);
      apply_table("t3", e);

      // 4: software re-sequence from DONE
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      p = cyc;
      chk("t4_sw_rst_n", rst_n, 4'b0000);
      chk("t4_sw_done", done, 1'b0);
      chk("t4_sw_state", st, 2'd1);
      goto(p + 47);
      chk("t4_pre_release", rst_n, 4'b0000);
      goto(p + 48);
      chk("t4_first_release", rst_n, 4'b0001);
      goto(p + 144);
      chk("t4_all_released", rst_n, 4'b1111);
      chk("t4_done", done, 1'b1);

      // 5: POR loss and software request in the same cycle; POR wins
      por_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_still_done", st, 2'd3);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      chk("t5_priority_state", st, 2'd0);
      chk("t5_priority_rst_n", rst_n, 4'b0000);

      // software request is ignored during FILTER
      por_n = 1'b1;
      wait_st(0, 2'd1, 10, "t5_filter", e);
      goto(e + 5);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      chk("t5_sw_ignored_state", st, 2'd1);
      goto(e + 47);
      chk("t5_sw_ignored_pre", rst_n, 4'b0000);
      goto(e + 48);
      chk("t5_sw_ignored_release", rst_n, 4'b0001);

      // 6: NUM_CH=1, STAGE_DLY=1, FILTER_CYC=1
      rst2 = 1'b0;
      wait_st(1, 2'd1, 10, "t6_filter", e);
      chk("t6_E_rst_n", rst_n2, 1'b0);
      @(negedge clk);
      chk("t6_release_state", st2, 2'd2);
      chk("t6_release_rst_n", rst_n2, 1'b0);
      @(negedge clk);
      chk("t6_rst_n", rst_n2, 1'b1);
      chk("t6_done", done2, 1'b1);
      chk("t6_state", st2, 2'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
